// File: rtl/gt_link_pkg.sv
// Shared types for the GTX receive-link monitor: state encoding used by the FSM and the debug port.
package gt_link_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_WAIT_DONE  = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_LINK_UP    = 3'd4,
    ST_RETRAIN    = 3'd5
  } link_state_e;

endpackage

// File: rtl/gt_status_sync.sv
// Two-flop synchronizer bank for asynchronous transceiver status bits.
module gt_status_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  // First flop may go metastable; second flop gives a settled value two cycles later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/gt_link_monitor.sv
// Receive-side link monitor: qualifies lock/reset-done/alignment, declares link up,
// accumulates 8b/10b error symbols and requests a retrain on status loss or error bursts.
module gt_link_monitor
  import gt_link_pkg::*;
#(
  parameter int LOCK_WAIT  = 8,
  parameter int TIMEOUT    = 4096,
  parameter int ERR_WIN    = 1024,
  parameter int ERR_MAX    = 16,
  parameter int RETRY_HOLD = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            en,
  input  logic            clear_cnt,
  input  logic            gt0_cplllock_in,
  input  logic            gt0_rxresetdone_in,
  input  logic            gt0_txresetdone_in,
  input  logic            gt0_rxbyteisaligned_in,
  input  logic [1:0]      gt0_rxdisperr_in,
  input  logic [1:0]      gt0_rxnotintable_in,
  output logic            link_up,
  output logic            retrain_req,
  output logic [15:0]     err_count,
  output logic [7:0]      retrain_count,
  output logic [ST_W-1:0] state_out
);

  localparam int STAB_W  = $clog2(LOCK_WAIT + 1);
  localparam int DWELL_W = 16;
  localparam int WIN_W   = $clog2(ERR_WIN + 1);
  localparam int SUM_W   = $clog2(2 * ERR_WIN + 2);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  link_state_e        state;
  link_state_e        state_nxt;
  logic [2:0]         status_s;
  logic               lock_s;
  logic               rxdone_s;
  logic               txdone_s;
  logic [STAB_W-1:0]  stable_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [SUM_W-1:0]   win_sum;
  logic [SUM_W-1:0]   win_sum_inc;
  logic [1:0]         err_bits;
  logic [1:0]         err_sym;
  logic               entry;
  logic               stable_hit;
  logic               tmo_hit;
  logic               hold_done;
  logic               win_end;
  logic               err_hit;

  gt_status_sync #(.WIDTH(3)) u_status_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     ({gt0_txresetdone_in, gt0_rxresetdone_in, gt0_cplllock_in}),
    .q     (status_s)
  );

  assign lock_s   = status_s[0];
  assign rxdone_s = status_s[1];
  assign txdone_s = status_s[2];

  // Per-cycle error symbols (0..2) and the window sum including this cycle.
  assign err_bits    = gt0_rxdisperr_in | gt0_rxnotintable_in;
  assign err_sym     = {1'b0, err_bits[1]} + {1'b0, err_bits[0]};
  assign win_sum_inc = win_sum + SUM_W'(err_sym);

  assign stable_hit = (stable_cnt == STAB_W'(LOCK_WAIT - 1));
  assign tmo_hit    = (dwell_cnt == DWELL_W'(TIMEOUT - 1));
  assign hold_done  = (dwell_cnt == DWELL_W'(RETRY_HOLD - 1));
  assign win_end    = (win_cnt == WIN_W'(ERR_WIN - 1));
  assign err_hit    = (win_sum_inc >= SUM_W'(ERR_MAX));
  assign entry      = (state_nxt != state);

  // Next-state: enable first, then status loss, then error threshold, then timeout.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s && stable_hit)    state_nxt = ST_WAIT_DONE;
          else if (tmo_hit)            state_nxt = ST_RETRAIN;
        end
        ST_WAIT_DONE: begin
          if (!lock_s)                 state_nxt = ST_RETRAIN;
          else if (rxdone_s && txdone_s) state_nxt = ST_WAIT_ALIGN;
          else if (tmo_hit)            state_nxt = ST_RETRAIN;
        end
        ST_WAIT_ALIGN: begin
          if (!(lock_s && rxdone_s && txdone_s))          state_nxt = ST_RETRAIN;
          else if (gt0_rxbyteisaligned_in && stable_hit)  state_nxt = ST_LINK_UP;
          else if (tmo_hit)                               state_nxt = ST_RETRAIN;
        end
        ST_LINK_UP: begin
          if (!(lock_s && rxdone_s && txdone_s && gt0_rxbyteisaligned_in)) state_nxt = ST_RETRAIN;
          else if (err_hit)            state_nxt = ST_RETRAIN;
        end
        ST_RETRAIN: begin
          if (hold_done)               state_nxt = ST_WAIT_LOCK;
        end
        default:                       state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Consecutive-stable counter for lock (WAIT_LOCK) and alignment (WAIT_ALIGN).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable_cnt <= '0;
    end else if (entry) begin
      stable_cnt <= '0;
    end else if ((state == ST_WAIT_LOCK && lock_s) ||
                 (state == ST_WAIT_ALIGN && gt0_rxbyteisaligned_in)) begin
      stable_cnt <= stable_cnt + STAB_W'(1);
    end else begin
      stable_cnt <= '0;
    end
  end

  // Cycles spent in the current state; drives both the WAIT_* timeout and the retrain hold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dwell_cnt <= '0;
    end else if (entry) begin
      dwell_cnt <= '0;
    end else if (dwell_cnt != '1) begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  // Error window: restarts at every window boundary and whenever the link is not up.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      win_cnt <= '0;
      win_sum <= '0;
    end else if (state != ST_LINK_UP || win_end) begin
      win_cnt <= '0;
      win_sum <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      win_sum <= win_sum_inc;
    end
  end

  // Saturating statistics; a clear pulse overrides any same-cycle increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_count     <= '0;
      retrain_count <= '0;
    end else if (clear_cnt) begin
      err_count     <= '0;
      retrain_count <= '0;
    end else begin
      if (state == ST_LINK_UP)
        err_count <= sat_add16(err_count, err_sym);
      if (state_nxt == ST_RETRAIN && state != ST_RETRAIN)
        retrain_count <= sat_inc8(retrain_count);
    end
  end

  assign link_up     = (state == ST_LINK_UP);
  assign retrain_req = (state == ST_RETRAIN);
  assign state_out   = state;

endmodule

// File: tb/tb_gt_link_monitor.sv
// Directed bench for gt_link_monitor with a queue of expected values popped at each observation.
`timescale 1ns/1ps
module tb_gt_link_monitor;

  localparam int LOCK_WAIT  = 8;
  localparam int TIMEOUT    = 64;
  localparam int ERR_WIN    = 16;
  localparam int ERR_MAX    = 4;
  localparam int RETRY_HOLD = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        en = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        lock = 1'b0;
  logic        rxdone = 1'b0;
  logic        txdone = 1'b0;
  logic        aligned = 1'b0;
  logic [1:0]  disperr = 2'b00;
  logic [1:0]  notintable = 2'b00;
  logic        link_up;
  logic        retrain_req;
  logic [15:0] err_count;
  logic [7:0]  retrain_count;
  logic [2:0]  state_out;

  int          errors = 0;
  int          checks = 0;
  int          req_cnt = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  gt_link_monitor #(
    .LOCK_WAIT  (LOCK_WAIT),
    .TIMEOUT    (TIMEOUT),
    .ERR_WIN    (ERR_WIN),
    .ERR_MAX    (ERR_MAX),
    .RETRY_HOLD (RETRY_HOLD)
  ) dut (
    .CLK                    (CLK),
    .RST_N                  (RST_N),
    .en                     (en),
    .clear_cnt              (clear_cnt),
    .gt0_cplllock_in        (lock),
    .gt0_rxresetdone_in     (rxdone),
    .gt0_txresetdone_in     (txdone),
    .gt0_rxbyteisaligned_in (aligned),
    .gt0_rxdisperr_in       (disperr),
    .gt0_rxnotintable_in    (notintable),
    .link_up                (link_up),
    .retrain_req            (retrain_req),
    .err_count              (err_count),
    .retrain_count          (retrain_count),
    .state_out              (state_out)
  );

  always #5 CLK = ~CLK;

  // Cycles with retrain_req high, sampled mid-cycle.
  always @(negedge CLK) if (retrain_req === 1'b1) req_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    string       t;
    logic [31:0] e;
    checks++;
    if (val_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", act);
      return;
    end
    t = tag_q.pop_front();
    e = val_q.pop_front();
    assert (act === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", t, act, e);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state_out !== s && n < budget) begin
      step(1);
      n++;
    end
    push(tag, 32'(s));
    pop_cmp(32'(state_out));
  endtask

  task automatic check_reset_outputs(input string pfx);
    push({pfx, "_link_up"}, 32'd0);       pop_cmp(32'(link_up));
    push({pfx, "_retrain_req"}, 32'd0);   pop_cmp(32'(retrain_req));
    push({pfx, "_err_count"}, 32'd0);     pop_cmp(32'(err_count));
    push({pfx, "_retrain_count"}, 32'd0); pop_cmp(32'(retrain_count));
    push({pfx, "_state_out"}, 32'd0);     pop_cmp(32'(state_out));
  endtask

  initial begin
    int base;
    int cnt;
    int exp_err;

    // Reset state
    step(2);
    check_reset_outputs("reset");

    RST_N = 1'b1;
    lock = 1'b1; rxdone = 1'b1; txdone = 1'b1; aligned = 1'b1;
    step(4);
    push("idle_while_disabled", 32'd0); pop_cmp(32'(state_out));

    // Lock glitch at stable count 5: lock_s low for one cycle restarts the count
    en = 1'b1;
    step(4);
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    step(9);
    push("glitch_still_wait_lock", 32'd1); pop_cmp(32'(state_out));
    step(1);
    push("glitch_wait_done", 32'd2); pop_cmp(32'(state_out));

    // Nominal bring-up
    wait_state("bringup_link_up_state", 3'd4, 40);
    push("bringup_link_up", 32'd1);       pop_cmp(32'(link_up));
    push("bringup_retrain_count", 32'd0); pop_cmp(32'(retrain_count));
    push("bringup_req_never", 32'd0);     pop_cmp(32'(req_cnt));

    // Error burst: two cycles of 2 symbols reach ERR_MAX=4
    base = req_cnt;
    disperr = 2'b11;
    step(1);
    push("burst_first_still_up", 32'd1); pop_cmp(32'(link_up));
    step(1);
    disperr = 2'b00;
    push("burst_link_down", 32'd0);      pop_cmp(32'(link_up));
    push("burst_state_retrain", 32'd5);  pop_cmp(32'(state_out));
    push("burst_err_count", 32'd4);      pop_cmp(32'(err_count));
    push("burst_retrain_count", 32'd1);  pop_cmp(32'(retrain_count));
    for (int i = 0; i < RETRY_HOLD; i++) begin
      push("burst_req_hold", 32'd1); pop_cmp(32'(retrain_req));
      step(1);
    end
    push("burst_after_hold_state", 32'd1);     pop_cmp(32'(state_out));
    push("burst_req_cycles", 32'(RETRY_HOLD)); pop_cmp(32'(req_cnt - base));

    // Re-link, then clear both statistics
    wait_state("relink_after_burst", 3'd4, 40);
    clear_cnt = 1'b1;
    step(1);
    clear_cnt = 1'b0;
    push("clear_err_count", 32'd0);     pop_cmp(32'(err_count));
    push("clear_retrain_count", 32'd0); pop_cmp(32'(retrain_count));

    // Sub-threshold spread: 3 symbols per 16 cycles for 5 blocks
    exp_err = 0;
    for (int b = 0; b < 5; b++) begin
      for (int o = 0; o < 16; o++) begin
        disperr    = (o == 0 || o == 10) ? 2'b01 : 2'b00;
        notintable = (o == 5) ? 2'b10 : ((o == 10) ? 2'b01 : 2'b00);
        exp_err    = exp_err + $countones(disperr | notintable);
        step(1);
      end
    end
    disperr = 2'b00;
    notintable = 2'b00;
    push("spread_state_up", 32'd4);     pop_cmp(32'(state_out));
    push("spread_err_count", 32'(exp_err)); pop_cmp(32'(err_count));
    push("spread_no_retrain", 32'd0);   pop_cmp(32'(retrain_count));

    // clear_cnt wins over a same-cycle error
    step(20);
    disperr = 2'b01;
    clear_cnt = 1'b1;
    step(1);
    disperr = 2'b00;
    clear_cnt = 1'b0;
    push("clear_vs_err_count", 32'd0); pop_cmp(32'(err_count));
    push("clear_vs_err_link", 32'd1);  pop_cmp(32'(link_up));

    // Alignment loss, then timeout in WAIT_ALIGN
    aligned = 1'b0;
    step(1);
    push("align_loss_retrain", 32'd5);  pop_cmp(32'(state_out));
    push("align_loss_count", 32'd1);    pop_cmp(32'(retrain_count));
    clear_cnt = 1'b1;
    step(1);
    clear_cnt = 1'b0;
    push("mid_retrain_clear", 32'd0);   pop_cmp(32'(retrain_count));
    wait_state("timeout_reach_wait_align", 3'd3, 40);
    cnt = 0;
    do begin
      cnt++;
      step(1);
    end while (state_out === 3'd3 && cnt < 200);
    push("timeout_cycles", 32'(TIMEOUT)); pop_cmp(32'(cnt));
    push("timeout_state", 32'd5);         pop_cmp(32'(state_out));
    for (int i = 0; i < RETRY_HOLD; i++) begin
      push("timeout_req_hold", 32'd1); pop_cmp(32'(retrain_req));
      step(1);
    end
    push("timeout_back_wait_lock", 32'd1); pop_cmp(32'(state_out));
    push("timeout_retrain_count", 32'd1);  pop_cmp(32'(retrain_count));

    // en dropped mid-RETRAIN
    aligned = 1'b1;
    wait_state("relink_before_en_drop", 3'd4, 40);
    aligned = 1'b0;
    step(1);
    step(1);
    push("en_drop_in_retrain", 32'd1); pop_cmp(32'(retrain_req));
    en = 1'b0;
    step(1);
    push("en_drop_state_idle", 32'd0);   pop_cmp(32'(state_out));
    push("en_drop_req_low", 32'd0);      pop_cmp(32'(retrain_req));
    push("en_drop_count_kept", 32'd2);   pop_cmp(32'(retrain_count));

    // Asynchronous reset in LINK_UP
    en = 1'b1;
    aligned = 1'b1;
    wait_state("relink_before_reset", 3'd4, 40);
    disperr = 2'b01;
    step(1);
    disperr = 2'b00;
    push("pre_reset_err_count", 32'd1); pop_cmp(32'(err_count));
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gt_link_monitor.md
# gt_link_monitor

Receive-side status monitor for the GTX loopback link. It consumes the transceiver's lock, reset-done, alignment and 8b/10b error status, decides when the link is up, and tracks error statistics. On loss of status or an error burst, it asserts a retrain request back toward the reset/configuration controller. It is the status-consuming counterpart to the block that drives CPLL/GT resets and userrdy, and sits in the `CLK` (rxusrclk2) domain next to it.

## Interface
Parameters:
- `LOCK_WAIT`, 8: consecutive stable cycles required on lock and on alignment before advancing.
- `TIMEOUT`, 4096: cycles allowed in any WAIT_* state before forcing a retrain; width 16 bits.
- `ERR_WIN`, 1024: error-window length in cycles.
- `ERR_MAX`, 16: error symbols per window that trigger a retrain; valid range 1..2*ERR_WIN.
- `RETRY_HOLD`, 16: cycles `retrain_req` is held high.

Ports:
- `CLK` in 1: single clock (rxusrclk2). Everything below is synchronous to it.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `en` in 1: monitor enable. While low, the block is held in IDLE.
- `clear_cnt` in 1: single-cycle pulse that clears `err_count` and `retrain_count`.
- `gt0_cplllock_in` in 1: CPLL lock. Asynchronous; synchronized internally.
- `gt0_rxresetdone_in` in 1: RX reset done. Asynchronous; synchronized internally.
- `gt0_txresetdone_in` in 1: TX reset done. Asynchronous; synchronized internally.
- `gt0_rxbyteisaligned_in` in 1: comma alignment. Already in the `CLK` domain.
- `gt0_rxdisperr_in` in 2: per-byte disparity error, `CLK` domain.
- `gt0_rxnotintable_in` in 2: per-byte not-in-table error, `CLK` domain.
- `link_up` out 1: high only in the LINK_UP state.
- `retrain_req` out 1: retrain request toward the reset controller.
- `err_count` out 16: total error symbols seen in LINK_UP. Saturates at 0xFFFF.
- `retrain_count` out 8: number of retrains. Saturates at 0xFF.
- `state_out` out 3: current state encoding, for debug/ILA.

## Operation
- Synchronizers: lock and both resetdone inputs each pass through a 2-flop synchronizer (2-cycle latency). Downstream logic uses the synchronized values (`_s` suffix below).
- States, with encoding: IDLE=0, WAIT_LOCK=1, WAIT_DONE=2, WAIT_ALIGN=3, LINK_UP=4, RETRAIN=5.
- IDLE:
  - `en`=1 moves to WAIT_LOCK.
- WAIT_LOCK:
  - The stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - When the counter reaches `LOCK_WAIT`, move to WAIT_DONE.
- WAIT_DONE:
  - `rxresetdone_s` and `txresetdone_s` both 1 moves to WAIT_ALIGN.
  - `lock_s`=0 moves to RETRAIN.
- WAIT_ALIGN:
  - The stable counter counts consecutive `rxbyteisaligned`=1 cycles.
  - When it reaches `LOCK_WAIT`, move to LINK_UP.
  - `lock_s`=0 or either resetdone=0 moves to RETRAIN.
- Timeout: the counter clears on every state entry. If it reaches `TIMEOUT` in any WAIT_* state, move to RETRAIN.
- LINK_UP:
  - If `lock_s`, either resetdone, or `rxbyteisaligned` is 0, move to RETRAIN on the next cycle.
  - Each cycle, error symbols = popcount(`rxdisperr` | `rxnotintable`), a value of 0..2.
  - These symbols accumulate into the window sum and into `err_count`.
  - If the window sum including the current cycle is ≥ `ERR_MAX`, move to RETRAIN.
  - At the end of each `ERR_WIN`-cycle window, the window sum and window counter restart at 0. Both also clear on LINK_UP entry.
- RETRAIN:
  - `retrain_count` increments on entry (saturating).
  - `retrain_req`=1 for exactly `RETRY_HOLD` cycles, then move to WAIT_LOCK.
- Priority: `en`=0 (to IDLE) > status loss > error threshold > timeout.
- `clear_cnt` beats a simultaneous increment: the counter reads 0 on the next cycle.
- Saturating counters hold their maximum value and never wrap.

## Timing
- Reset values: state IDLE, `link_up`=0, `retrain_req`=0, `err_count`=0, `retrain_count`=0, `state_out`=0. All internal counters and synchronizer flops are 0.
- All outputs are registered. `link_up` and `retrain_req` are decoded from the state register, with no combinational path from the inputs.
- `en` deasserting mid-RETRAIN drops `retrain_req` on the next cycle. The remaining hold is abandoned and the counters are kept.
- Lock input to WAIT_DONE: lock rising on cycle 0 gives `lock_s` at cycle 2, and the state reaches WAIT_DONE at cycle 2+`LOCK_WAIT`.
- LINK_UP exit on an error burst: the state changes on the edge after the threshold cycle, so `link_up` falls 1 cycle after the offending symbol.
- `RST_N` assertion mid-operation clears everything asynchronously. Release is used synchronously by a reset synchronizer at the top level (outside this block).

## Structure
- Package `gt_link_pkg`: state enum with the fixed 3-bit encoding, and `ST_W`=3.
- Sub-module `gt_status_sync`: parameterized-width 2-flop synchronizer, instantiated once with width 3.
- The FSM, counters and error accumulation live in `gt_link_monitor`.

## Test plan
Parameters for all scenarios: `LOCK_WAIT`=8, `TIMEOUT`=64, `ERR_WIN`=16, `ERR_MAX`=4, `RETRY_HOLD`=4.
- Nominal bring-up: `en`=1, then lock, both resetdone and aligned all held at 1 → `link_up`=1 and `state_out`=4, with `retrain_count`=0 and `retrain_req` never asserted.
- Lock glitch: lock drops for 1 cycle at stable count 5 in WAIT_LOCK → stable count restarts. WAIT_DONE is reached 8 cycles after `lock_s` returns.
- Timeout: aligned held at 0 → after 64 cycles in WAIT_ALIGN the block enters RETRAIN. `retrain_req` is high for 4 cycles, then the state is WAIT_LOCK with `retrain_count`=1.
- Error burst: in LINK_UP, `rxdisperr`=2'b11 on two consecutive cycles → window sum 4, `link_up` falls 1 cycle after the second error, `err_count`=4.
- Sub-threshold spread: in LINK_UP, 3 error symbols per 16-cycle window for 5 windows → no retrain, `err_count`=15.
- Control corner cases:
  - `clear_cnt` asserted in the same cycle as an error → `err_count`=0.
  - `en`=0 during RETRAIN → IDLE and `retrain_req`=0 on the next cycle.
  - `RST_N` low mid-LINK_UP → all outputs take their reset values immediately.
